cflog_writer: RTL and testbench

CFLOG_WRITER -- requirements
Module: cflog_writer

---
 rtl/cflog_pkg.sv | 32 +++
 rtl/cflog_fifo.sv | 83 ++++++++
 rtl/cflog_writer.sv | 188 ++++++++++++++++++
 tb/tb_cflog_writer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cflog_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cflog_pkg : shared types and helpers for the control-flow log writer
// Rev 1.0
// ----------------------------------------------------------------------------
package cflog_pkg;

  localparam logic [15:0] LOG_SIZE_DEFAULT = 16'h0400;
  localparam int          ENTRY_W          = 48;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_SRC  = 2'd1,
    ST_WR_DEST = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] ptr;
    logic [15:0] src;
    logic [15:0] dest;
  } entry_t;

  // Byte address of a 16-bit log slot; shifting by one drops bit 15 of the index.
  function automatic logic [15:0] slot_addr(input logic [15:0] base,
                                            input logic [15:0] word_idx);
    logic [15:0] byte_off;
    byte_off  = word_idx << 1;
    slot_addr = base + byte_off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cflog_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cflog_fifo : synchronous FIFO with registered storage, full/empty/count
// Rev 1.0
// ----------------------------------------------------------------------------
module cflog_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cflog_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cflog_writer : queues control-flow entries and writes them as two log words.
// Optional build macro CFLOG_DEDUP_EN drops repeats of the last accepted entry.
// Rev 1.0
// ----------------------------------------------------------------------------
module cflog_writer
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_SIZE   = LOG_SIZE_DEFAULT,
  parameter logic [15:0] LOG_BASE   = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        puc,
  input  logic        cflow_hw_wen,
  input  logic [15:0] cflow_log_ptr,
  input  logic [15:0] cflow_src,
  input  logic [15:0] cflow_dest,
  input  logic        flush,
  input  logic        cpu_mem_req,
  output logic        log_we,
  output logic [15:0] log_addr,
  output logic [15:0] log_wdata,
  output logic        fifo_full,
  output logic        overflow,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] PTR_MAX = LOG_SIZE - 16'd2;

  state_e             state_q;
  entry_t             hold_q;
  entry_t             in_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               overflow_q;
  logic               in_bounds;
  logic               is_dup;
  logic               accept;
  logic               lost;
  logic               drain;

  assign in_bounds  = (cflow_log_ptr <= PTR_MAX);
  assign in_entry   = '{ptr: cflow_log_ptr, src: cflow_src, dest: cflow_dest};
  assign head_entry = entry_t'(fifo_dout);

  assign accept    = cflow_hw_wen && !flush && in_bounds && !is_dup;
  assign fifo_push = accept && !fifo_full;
  assign lost      = (cflow_hw_wen && !flush && !in_bounds) || (accept && fifo_full);

  // The FSM takes a new entry from IDLE, or straight after the dest word lands.
  assign drain    = (state_q == ST_IDLE) || ((state_q == ST_WR_DEST) && !cpu_mem_req);
  assign fifo_pop = drain && !fifo_empty && !flush;

  cflog_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (puc),
    .clr_i   (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (in_entry),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef CFLOG_DEDUP_EN
  logic        last_vld_q;
  logic [15:0] last_src_q;
  logic [15:0] last_dest_q;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  assign is_dup = last_vld_q && (cflow_src == last_src_q) && (cflow_dest == last_dest_q);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cflow_hw_wen && !flush && in_bounds && is_dup && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (puc) begin
      last_vld_q  <= 1'b0;
      last_src_q  <= '0;
      last_dest_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (flush) begin
        last_vld_q <= 1'b0;
      end else if (fifo_push) begin
        last_vld_q  <= 1'b1;
        last_src_q  <= cflow_src;
        last_dest_q <= cflow_dest;
      end
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign is_dup   = 1'b0;
  assign drop_cnt = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (puc) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            hold_q  <= head_entry;
            state_q <= ST_WR_SRC;
          end
        end
        ST_WR_SRC: begin
          if (!cpu_mem_req) begin
            state_q <= ST_WR_DEST;
          end
        end
        ST_WR_DEST: begin
          if (!cpu_mem_req) begin
            if (fifo_pop) begin
              hold_q  <= head_entry;
              state_q <= ST_WR_SRC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (puc || flush) begin
      overflow_q <= 1'b0;
    end else if (lost) begin
      overflow_q <= 1'b1;
    end
  end

  // Address and data stay valid through a CPU stall; only the strobe is withheld.
  always_comb begin
    log_we    = 1'b0;
    log_addr  = '0;
    log_wdata = '0;
    case (state_q)
      ST_WR_SRC: begin
        log_we    = 1'b1;
        log_addr  = slot_addr(LOG_BASE, hold_q.ptr);
        log_wdata = hold_q.src;
      end
      ST_WR_DEST: begin
        log_we    = 1'b1;
        log_addr  = slot_addr(LOG_BASE, hold_q.ptr + 16'd1);
        log_wdata = hold_q.dest;
      end
      default: begin
        log_we = 1'b0;
      end
    endcase
    if (cpu_mem_req || flush || puc) begin
      log_we = 1'b0;
    end
  end

  assign overflow = overflow_q;
  assign busy     = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cflog_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cflog_writer : directed self-checking bench for cflog_writer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cflog_writer;

  logic        clk = 1'b0;
  logic        puc = 1'b1;
  logic        cflow_hw_wen = 1'b0;
  logic [15:0] cflow_log_ptr = '0;
  logic [15:0] cflow_src = '0;
  logic [15:0] cflow_dest = '0;
  logic        flush = 1'b0;
  logic        cpu_mem_req = 1'b0;
  logic        log_we;
  logic [15:0] log_addr;
  logic [15:0] log_wdata;
  logic        fifo_full;
  logic        overflow;
  logic        busy;
  logic [7:0]  drop_cnt;

`ifdef CFLOG_DEDUP_EN
  localparam int          DUP_WRITES = 2;
  localparam logic [7:0]  DUP_DROPS  = 8'd2;
`else
  localparam int          DUP_WRITES = 6;
  localparam logic [7:0]  DUP_DROPS  = 8'd0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t0     = 0;
  logic [63:0] wq[$];

  cflog_writer dut (
    .clk           (clk),
    .puc           (puc),
    .cflow_hw_wen  (cflow_hw_wen),
    .cflow_log_ptr (cflow_log_ptr),
    .cflow_src     (cflow_src),
    .cflow_dest    (cflow_dest),
    .flush         (flush),
    .cpu_mem_req   (cpu_mem_req),
    .log_we        (log_we),
    .log_addr      (log_addr),
    .log_wdata     (log_wdata),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every RAM write is logged as {cycle, addr, data}.
  always @(negedge clk) begin
    if (log_we) wq.push_back({32'(cyc), log_addr, log_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_wr(input string tag, input int i, input int c,
                        input logic [15:0] a, input logic [15:0] d);
    logic [63:0] obs;
    obs = (i < wq.size()) ? wq[i] : {64{1'b1}};
    chk(tag, obs, {32'(c), a, d});
  endtask

  task automatic drive(input logic wen, input logic [15:0] ptr, input logic [15:0] src,
                       input logic [15:0] dest, input logic req, input logic fl);
    cflow_hw_wen  = wen;
    cflow_log_ptr = ptr;
    cflow_src     = src;
    cflow_dest    = dest;
    cpu_mem_req   = req;
    flush         = fl;
    #2;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      nxt();
    end
  endtask

  initial begin
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) nxt();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_we", 64'(log_we), 64'd0);
    chk("rst_addr", 64'(log_addr), 64'd0);
    chk("rst_wdata", 64'(log_wdata), 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    puc = 1'b0;
    nxt();
    idle(2);

    // Single entry: src two cycles after the strobe, dest one later.
    wq.delete(); t0 = cyc;
    drive(1'b1, 16'd4, 16'hE100, 16'hE200, 1'b0, 1'b0); nxt();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("single_busy", 64'(busy), 64'd1);
    nxt();
    idle(6);
    chk("single_n", 64'(wq.size()), 64'd2);
    chk_wr("single_src", 0, t0 + 2, 16'h0008, 16'hE100);
    chk_wr("single_dest", 1, t0 + 3, 16'h000A, 16'hE200);
    chk("single_idle", 64'(busy), 64'd0);

    // CPU stall on cycles 2-4.
    wq.delete(); t0 = cyc;
    drive(1'b1, 16'h000A, 16'h1111, 16'h2222, 1'b0, 1'b0); nxt();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0); nxt();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("stall_we", 64'(log_we), 64'd0);
      chk("stall_addr", 64'(log_addr), 64'h0014);
      chk("stall_data", 64'(log_wdata), 64'h1111);
      nxt();
    end
    idle(5);
    chk("stall_n", 64'(wq.size()), 64'd2);
    chk_wr("stall_src", 0, t0 + 5, 16'h0014, 16'h1111);
    chk_wr("stall_dest", 1, t0 + 6, 16'h0016, 16'h2222);

    // Six back-to-back strobes while the CPU holds the RAM: the sixth is lost.
    wq.delete(); t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 16'h0020 + 16'(2 * k), 16'hA000 + 16'(k), 16'hB000 + 16'(k), 1'b1, 1'b0);
      chk("burst_full", 64'(fifo_full), 64'(k == 5));
      nxt();
    end
    chk("burst_ovf", 64'(overflow), 64'd1);
    idle(12);
    chk("burst_n", 64'(wq.size()), 64'd10);
    for (int k = 0; k < 5; k++) begin
      chk_wr("burst_src", 2 * k, t0 + 6 + 2 * k, 16'h0040 + 16'(4 * k), 16'hA000 + 16'(k));
      chk_wr("burst_dest", 2 * k + 1, t0 + 7 + 2 * k, 16'h0042 + 16'(4 * k), 16'hB000 + 16'(k));
    end
    chk("burst_idle", 64'(busy), 64'd0);

    // Flush during the first entry's dest cycle with two entries queued.
    wq.delete(); t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0100 + 16'(2 * k), 16'hC000 + 16'(k), 16'hD000 + 16'(k), 1'b0, 1'b0);
      nxt();
    end
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("flush_we", 64'(log_we), 64'd0);
    chk("flush_busy_pre", 64'(busy), 64'd1);
    nxt();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    nxt();
    idle(6);
    chk("flush_n", 64'(wq.size()), 64'd1);
    chk_wr("flush_src", 0, t0 + 2, 16'h0200, 16'hC000);

    // Last legal slot pair, then one past it.
    wq.delete(); t0 = cyc;
    drive(1'b1, 16'h03FE, 16'h5555, 16'h6666, 1'b0, 1'b0); nxt();
    idle(6);
    chk("edge_n", 64'(wq.size()), 64'd2);
    chk_wr("edge_src", 0, t0 + 2, 16'h07FC, 16'h5555);
    chk_wr("edge_dest", 1, t0 + 3, 16'h07FE, 16'h6666);
    chk("edge_ovf", 64'(overflow), 64'd0);
    wq.delete();
    drive(1'b1, 16'h03FF, 16'h7777, 16'h8888, 1'b0, 1'b0); nxt();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("oob_busy", 64'(busy), 64'd0);
    nxt();
    idle(5);
    chk("oob_n", 64'(wq.size()), 64'd0);
    chk("oob_ovf", 64'(overflow), 64'd1);

    // Three identical entries.
    wq.delete(); t0 = cyc;
    repeat (3) begin
      drive(1'b1, 16'h0040, 16'hC0DE, 16'hD00D, 1'b0, 1'b0);
      nxt();
    end
    idle(10);
    chk("dup_n", 64'(wq.size()), 64'(DUP_WRITES));
    chk("dup_drop", 64'(drop_cnt), 64'(DUP_DROPS));
    chk_wr("dup_src", 0, t0 + 2, 16'h0080, 16'hC0DE);
    chk_wr("dup_dest", 1, t0 + 3, 16'h0082, 16'hD00D);

    // Reset in the src-write cycle abandons the entry.
    wq.delete();
    drive(1'b1, 16'h0050, 16'h1234, 16'h5678, 1'b0, 1'b0); nxt();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0); nxt();
    puc = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rstmid_we", 64'(log_we), 64'd0);
    nxt();
    puc = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_drop", 64'(drop_cnt), 64'd0);
    nxt();
    idle(5);
    chk("rstmid_n", 64'(wq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
